conv_lb_kline: RTL and testbench

Parametrised K-line buffer for the convolution front end. It accepts a raster pixel stream and emits, for every accepted pixel, a vertical column of `LINES_N` pixels at the same x position: the `LINES_N-1` previous rows plus the current pixel. It sits between the pixel source and the horizontal kernel window. It replaces a fixed two-bank line buffer with a single read-modify-write SRAM column store, a configurable line count, and valid/ready backpressure on both sides.

---
 rtl/conv_lb_kline.sv | 168 ++++++++++++++++
 tb/tb_conv_lb_kline.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_lb_kline.sv
// K-line column buffer: emits a LINES_N-tall pixel column for every accepted raster pixel.
// Optional feature macro: CONV_LB_ZERO_BORDER_EN (emit zero-padded columns while priming).
module conv_lb_kline #(
  parameter int unsigned PIXEL_W     = 8,
  parameter int unsigned LINES_N     = 3,
  parameter int unsigned IMAGE_MAX_W = 1024,
  parameter int unsigned X_W         = $clog2(IMAGE_MAX_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld_i,
  output logic                       in_rdy_o,
  input  logic [PIXEL_W-1:0]         in_dat_i,
  input  logic                       in_sof_i,
  input  logic                       in_eol_i,
  output logic                       out_vld_o,
  input  logic                       out_rdy_i,
  output logic [LINES_N*PIXEL_W-1:0] out_col_o,
  output logic                       out_sof_o,
  output logic                       out_eol_o,
  output logic                       err_o
);

  localparam int unsigned WORD_W = (LINES_N - 1) * PIXEL_W;
  localparam int unsigned COL_W  = LINES_N * PIXEL_W;
  localparam int unsigned P_W    = $clog2(LINES_N);
  localparam logic [P_W-1:0] PRIME_FULL = P_W'(LINES_N - 1);
  localparam logic [X_W-1:0] X_LAST     = X_W'(IMAGE_MAX_W - 1);

  logic [X_W-1:0]     x_q, x_nxt, rd_addr_c;
  logic [P_W-1:0]     prime_q, prime_nxt, pix_prime_c;
  logic               err_nxt;
  logic               acc_c, fwd_c;

  logic               s1_vld;
  logic [PIXEL_W-1:0] s1_pix;
  logic               s1_sof, s1_eol;
  logic [P_W-1:0]     s1_prime;
  logic [X_W-1:0]     s1_x;
  logic [WORD_W-1:0]  rd_q, wb_c;
  logic [COL_W-1:0]   col_c;
  logic               emit_c;

  logic               skid_vld;
  logic [COL_W-1:0]   skid_col;
  logic               skid_sof, skid_eol;
  logic               out_free_c;

  logic [WORD_W-1:0]  mem [IMAGE_MAX_W];

  assign acc_c       = in_vld_i & in_rdy_o;
  assign rd_addr_c   = in_sof_i ? '0 : x_q;
  assign pix_prime_c = in_sof_i ? '0 : prime_q;
  assign fwd_c       = acc_c & s1_vld & (rd_addr_c == s1_x);
  assign out_free_c  = ~out_vld_o | out_rdy_i;
  assign in_rdy_o    = ~skid_vld & ~(s1_vld & out_vld_o & ~out_rdy_i);

  // Column position, priming depth and overflow flag for the next pixel
  always_comb begin
    x_nxt     = x_q;
    prime_nxt = prime_q;
    err_nxt   = err_o;
    if (acc_c) begin
      prime_nxt = pix_prime_c;
      if (in_eol_i && (pix_prime_c != PRIME_FULL))
        prime_nxt = pix_prime_c + P_W'(1);
      if (in_sof_i)
        err_nxt = 1'b0;
      if (in_eol_i) begin
        x_nxt = '0;
      end else if (rd_addr_c == X_LAST) begin
        x_nxt   = '0;
        err_nxt = 1'b1;
      end else begin
        x_nxt = rd_addr_c + X_W'(1);
      end
    end
  end

  // S1 column assembly; the write-back drops the oldest row
  always_comb begin
    col_c  = {s1_pix, rd_q};
    wb_c   = col_c[COL_W-1:PIXEL_W];
    emit_c = 1'b0;
`ifdef CONV_LB_ZERO_BORDER_EN
    for (int unsigned r = 0; r < LINES_N - 1; r++)
      if (r + 32'(s1_prime) < LINES_N - 1)
        col_c[r*PIXEL_W +: PIXEL_W] = '0;
    emit_c = s1_vld;
`else
    emit_c = s1_vld & (s1_prime == PRIME_FULL);
`endif
  end

  // Column store; same-address read during write-back sees the new word
  always_ff @(posedge clk) begin
    if (s1_vld)
      mem[s1_x] <= wb_c;
    if (acc_c)
      rd_q <= fwd_c ? wb_c : mem[rd_addr_c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      prime_q  <= '0;
      err_o    <= 1'b0;
      s1_vld   <= 1'b0;
      s1_pix   <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_prime <= '0;
      s1_x     <= '0;
    end else begin
      x_q     <= x_nxt;
      prime_q <= prime_nxt;
      err_o   <= err_nxt;
      s1_vld  <= acc_c;
      if (acc_c) begin
        s1_pix   <= in_dat_i;
        s1_sof   <= in_sof_i;
        s1_eol   <= in_eol_i;
        s1_prime <= pix_prime_c;
        s1_x     <= rd_addr_c;
      end
    end
  end

  // Output register with one-entry skid; skid always refills the output first
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_o <= 1'b0;
      out_col_o <= '0;
      out_sof_o <= 1'b0;
      out_eol_o <= 1'b0;
      skid_vld  <= 1'b0;
      skid_col  <= '0;
      skid_sof  <= 1'b0;
      skid_eol  <= 1'b0;
    end else if (out_free_c) begin
      if (skid_vld) begin
        out_vld_o <= 1'b1;
        out_col_o <= skid_col;
        out_sof_o <= skid_sof;
        out_eol_o <= skid_eol;
        skid_vld  <= emit_c;
        if (emit_c) begin
          skid_col <= col_c;
          skid_sof <= s1_sof;
          skid_eol <= s1_eol;
        end
      end else if (emit_c) begin
        out_vld_o <= 1'b1;
        out_col_o <= col_c;
        out_sof_o <= s1_sof;
        out_eol_o <= s1_eol;
      end else begin
        out_vld_o <= 1'b0;
      end
    end else if (emit_c) begin
      skid_vld <= 1'b1;
      skid_col <= col_c;
      skid_sof <= s1_sof;
      skid_eol <= s1_eol;
    end
  end

endmodule

// File: tb/tb_conv_lb_kline.sv
// Directed bench for conv_lb_kline: frames, width-1 lines, backpressure, overflow, mid-line sof.
module tb_conv_lb_kline;

  localparam int unsigned PIXEL_W     = 8;
  localparam int unsigned LINES_N     = 3;
  localparam int unsigned IMAGE_MAX_W = 16;
  localparam int unsigned X_W         = 4;
  localparam int unsigned COL_W       = LINES_N * PIXEL_W;
`ifdef CONV_LB_ZERO_BORDER_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_vld, in_rdy, in_sof, in_eol;
  logic [PIXEL_W-1:0] in_dat;
  logic               out_vld, out_rdy, out_sof, out_eol, err;
  logic [COL_W-1:0]   out_col;

  conv_lb_kline #(
    .PIXEL_W(PIXEL_W), .LINES_N(LINES_N), .IMAGE_MAX_W(IMAGE_MAX_W), .X_W(X_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_vld_i(in_vld), .in_rdy_o(in_rdy), .in_dat_i(in_dat),
    .in_sof_i(in_sof), .in_eol_i(in_eol),
    .out_vld_o(out_vld), .out_rdy_i(out_rdy), .out_col_o(out_col),
    .out_sof_o(out_sof), .out_eol_o(out_eol), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PIXEL_W-1:0] pq_dat[$];
  bit                 pq_sof[$], pq_eol[$];
  logic [COL_W-1:0]   ex_col[$], got_col[$];
  bit                 ex_sof[$], ex_eol[$], got_sof[$], got_eol[$];
  int                 ex_pix[$], got_cyc[$], acc_cyc[$];
  int                 st_acc;
  logic               st_rdy;
  logic [COL_W-1:0]   st_col;

  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      got_col.push_back(out_col);
      got_sof.push_back(out_sof);
      got_eol.push_back(out_eol);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Column of frame row r at x with pixel value base+16*r+x; missing rows read as zero
  function automatic logic [COL_W-1:0] col_of(input int base, input int r, input int x);
    logic [7:0] s0, s1, s2;
    s2 = 8'(base + 16*r + x);
    s1 = (r >= 1) ? 8'(base + 16*(r-1) + x) : 8'h00;
    s0 = (r >= 2) ? 8'(base + 16*(r-2) + x) : 8'h00;
    return {s2, s1, s0};
  endfunction

  task automatic push_px(input logic [7:0] d, input bit s, input bit e, input bit emit,
                         input logic [COL_W-1:0] col);
    if (emit) begin
      ex_col.push_back(col);
      ex_sof.push_back(s);
      ex_eol.push_back(e);
      ex_pix.push_back(pq_dat.size());
    end
    pq_dat.push_back(d);
    pq_sof.push_back(s);
    pq_eol.push_back(e);
  endtask

  task automatic add_frame(input int base, input int width, input int rows);
    for (int r = 0; r < rows; r++)
      for (int x = 0; x < width; x++)
        push_px(8'(base + 16*r + x), (r == 0 && x == 0), (x == width-1), ZB || (r >= 2),
                col_of(base, r, x));
  endtask

  task automatic clear_all();
    pq_dat.delete(); pq_sof.delete(); pq_eol.delete();
    ex_col.delete(); ex_sof.delete(); ex_eol.delete(); ex_pix.delete();
    got_col.delete(); got_sof.delete(); got_eol.delete(); got_cyc.delete();
    acc_cyc.delete();
  endtask

  // Presents the pixel queue back-to-back; out_rdy is held low for cycles [st_start, st_start+st_len)
  task automatic run_stream(input int st_start, input int st_len);
    int idx = 0;
    int k = 0;
    int limit;
    limit = 4 * pq_dat.size() + 50;
    st_acc = 0;
    st_rdy = 1'b1;
    st_col = '0;
    while (idx < pq_dat.size() && k < limit) begin
      in_vld  = 1'b1;
      in_dat  = pq_dat[idx];
      in_sof  = pq_sof[idx];
      in_eol  = pq_eol[idx];
      out_rdy = !(k >= st_start && k < st_start + st_len);
      @(negedge clk);
      if (in_rdy) begin
        acc_cyc.push_back(cyc);
        if (!out_rdy) st_acc++;
        idx++;
      end
      if (k == st_start + st_len - 1) begin
        st_rdy = in_rdy;
        st_col = out_col;
      end
      @(posedge clk);
      #1;
      k++;
    end
    in_vld  = 1'b0;
    in_sof  = 1'b0;
    in_eol  = 1'b0;
    out_rdy = 1'b1;
    check("stream_done", idx, pq_dat.size());
  endtask

  task automatic drain();
    out_rdy = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input bit lat);
    check($sformatf("%s_count", tag), got_col.size(), ex_col.size());
    for (int i = 0; i < ex_col.size() && i < got_col.size(); i++) begin
      check($sformatf("%s_col%0d", tag, i), got_col[i], ex_col[i]);
      check($sformatf("%s_sof%0d", tag, i), got_sof[i], ex_sof[i]);
      check($sformatf("%s_eol%0d", tag, i), got_eol[i], ex_eol[i]);
      if (lat && ex_pix[i] < acc_cyc.size())
        check($sformatf("%s_lat%0d", tag, i), got_cyc[i], acc_cyc[ex_pix[i]] + 2);
    end
    clear_all();
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_dat = '0; in_sof = 1'b0; in_eol = 1'b0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;

    // Width-4 frame of three rows
    clear_all();
    add_frame(0, 4, 3);
    run_stream(0, 0);
    drain();
    check_outputs("f4", 1'b1);

    // Width-1 lines: consecutive pixels hit the same address
    for (int n = 1; n <= 4; n++)
      push_px(8'(n), (n == 1), 1'b1, ZB || (n >= 3),
              {8'(n), (n >= 2) ? 8'(n-1) : 8'h00, (n >= 3) ? 8'(n-2) : 8'h00});
    run_stream(0, 0);
    drain();
    check_outputs("w1", 1'b1);

    // Output stall as row 2 starts
    add_frame(0, 8, 3);
    run_stream(16, 5);
    check("stall_acc", st_acc, ZB ? 0 : 2);
    check("stall_rdy", st_rdy, 0);
    check("stall_hold", st_col, ZB ? col_of(0, 1, 6) : col_of(0, 2, 0));
    drain();
    check_outputs("stall", 1'b0);

    // Line overflow sets the sticky error; next sof clears it
    for (int x = 0; x < 15; x++) push_px(8'(x), (x == 0), 1'b0, 1'b0, '0);
    run_stream(0, 0);
    check("err_before_wrap", err, 0);
    clear_all();
    push_px(8'd15, 1'b0, 1'b0, 1'b0, '0);
    run_stream(0, 0);
    check("err_at_wrap", err, 1);
    clear_all();
    push_px(8'd16, 1'b0, 1'b0, 1'b0, '0);
    run_stream(0, 0);
    check("err_sticky", err, 1);
    clear_all();
    push_px(8'd0, 1'b1, 1'b0, 1'b0, '0);
    run_stream(0, 0);
    check("err_sof_clear", err, 0);
    drain();
    clear_all();

    // sof arriving in the middle of row 2
    add_frame(0, 4, 2);
    for (int x = 0; x < 2; x++) push_px(8'(32 + x), 1'b0, 1'b0, 1'b1, col_of(0, 2, x));
    add_frame(128, 4, 3);
    run_stream(0, 0);
    drain();
    check_outputs("sofmid", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
